// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment driver: sequential double-dabble binary-to-BCD conversion,
// display register, prescaled digit scan, leading-zero blanking, DP and overflow dash.
module fnd_scan_controller #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned SCAN_HZ = 1_000,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned VALUE_W = 14,
    parameter bit          SEG_AL  = 1'b1,
    parameter bit          SEL_AL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic               blank_lz,
    input  logic [DIGITS-1:0]  dp_mask,
    output logic               busy,
    output logic               overflow,
    output logic [DIGITS-1:0]  fndselect,
    output logic [7:0]         fndfont
);

    localparam int unsigned PRESC = (SCAN_HZ == 0) ? 0 : CLK_HZ / SCAN_HZ;
    localparam int unsigned PW    = (PRESC > 2) ? $clog2(PRESC) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CW    = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int unsigned BCD_W = 4 * DIGITS + 4;

    if (DIGITS < 1 || DIGITS > 8 || VALUE_W < 1 || VALUE_W > 27 || PRESC < 2) begin : g_param_check
        $error("fnd_scan_controller: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [VALUE_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d, bcd_adj;
    logic                sticky_q, sticky_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]          font_q, font_d;
    logic                tick;
    logic [DIGITS-1:0]   lz;
    logic [3:0]          nib;
    logic [6:0]          seg;
    logic                blank;

    function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int unsigned i = 0; i < BCD_W / 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load) state_d = S_SHIFT;
            S_SHIFT:  if (cnt_q == CW'(VALUE_W - 1)) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // Bits carried out of the top nibble set a sticky flag, so values far beyond
    // the register width still flag overflow instead of wrapping to a small count.
    always_comb begin
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        sticky_d = sticky_q;
        disp_d   = disp_q;
        ovf_d    = ovf_q;
        bcd_adj  = dabble(bcd_q);
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d    = value;
                    bcd_d    = '0;
                    sticky_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_SHIFT: begin
                bcd_d    = {bcd_adj[BCD_W-2:0], bin_q[VALUE_W-1]};
                bin_d    = bin_q << 1;
                sticky_d = sticky_q | bcd_adj[BCD_W-1];
                cnt_d    = cnt_q + 1'b1;
            end
            S_COMMIT: begin
                disp_d = bcd_q[4*DIGITS-1:0];
                ovf_d  = sticky_q | (bcd_q[BCD_W-1 -: 4] != 4'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            bin_q    <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            disp_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            sticky_q <= sticky_d;
            disp_q   <= disp_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        tick    = (presc_q == PW'(PRESC - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (tick) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
            lz[i] = ((disp_q >> (4 * i)) == '0);
        end
        nib   = disp_q[{idx_q, 2'b00} +: 4];
        blank = blank_lz && (idx_q != '0) && lz[idx_q];
        case (nib)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (ovf_q)      seg = 7'h40;
        else if (blank) seg = 7'h00;
        font_d = {dp_mask[idx_q], seg};
        if (SEG_AL) font_d = ~font_d;
        sel_d = '0;
        sel_d[idx_q] = 1'b1;
        if (SEL_AL) sel_d = ~sel_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            sel_q   <= SEL_AL ? '1 : '0;
            font_q  <= SEG_AL ? 8'hFF : 8'h00;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            font_q  <= font_d;
        end
    end

    assign overflow  = ovf_q;
    assign fndselect = sel_q;
    assign fndfont   = font_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: tick every 4 clocks, 4 digits, 14-bit value.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  dp_mask = '0;
    logic        busy;
    logic        overflow;
    logic [3:0]  fndselect;
    logic [7:0]  fndfont;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] obs_font [4];
    logic [3:0] obs_seen;
    int         bad_sel;
    int         order_err;

    fnd_scan_controller #(
        .CLK_HZ (1000),
        .SCAN_HZ(250),
        .DIGITS (4),
        .VALUE_W(14),
        .SEG_AL (1'b1),
        .SEL_AL (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .busy     (busy),
        .overflow (overflow),
        .fndselect(fndselect),
        .fndfont  (fndfont)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [13:0] v, output int busy_cycles);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    // Samples one full scan (16 clocks) and records the font seen for each digit.
    task automatic capture_scan();
        int d, prev;
        prev = -1;
        bad_sel = 0;
        order_err = 0;
        obs_seen = '0;
        for (int i = 0; i < 4; i++) obs_font[i] = 'x;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            case (fndselect)
                4'hE:    d = 0;
                4'hD:    d = 1;
                4'hB:    d = 2;
                4'h7:    d = 3;
                default: d = -1;
            endcase
            if (d < 0) bad_sel++;
            else begin
                obs_font[d] = fndfont;
                obs_seen[d] = 1'b1;
                if (prev >= 0 && d != prev && d != (prev + 1) % 4) order_err++;
                prev = d;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (fndselect !== 4'hF) begin n_fail++; $display("FAIL reset_sel: got %h expected F", fndselect); end
        n_checks++; if (fndfont !== 8'hFF) begin n_fail++; $display("FAIL reset_font: got %h expected FF", fndfont); end
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_sel = ~(4'b0001 << ((k - 1) / 4));
            n_checks++; if (fndselect !== exp_sel) begin n_fail++; $display("FAIL reset_scan_sel[%0d]: got %h expected %h", k, fndselect, exp_sel); end
            n_checks++; if (fndfont !== 8'hC0) begin n_fail++; $display("FAIL reset_scan_font[%0d]: got %h expected C0", k, fndfont); end
        end
    endtask

    task automatic test_convert();
        int bc;
        logic [7:0] exp [4];
        blank_lz = 1'b0; dp_mask = '0;
        do_load(14'd1234, bc);
        n_checks++; if (bc != 15) begin n_fail++; $display("FAIL convert_busy_cycles: got %0d expected 15", bc); end
        exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        capture_scan();
        n_checks++; if (bad_sel != 0 || obs_seen !== 4'hF) begin n_fail++; $display("FAIL convert_sel: bad=%0d seen=%b expected 0 and 1111", bad_sel, obs_seen); end
        n_checks++; if (order_err != 0) begin n_fail++; $display("FAIL convert_order: got %0d errors expected 0", order_err); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL convert_overflow: got %b expected 0", overflow); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL convert_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
    endtask

    task automatic test_leading_zero();
        int bc;
        logic [7:0] exp [4];
        blank_lz = 1'b1; dp_mask = '0;
        do_load(14'd7, bc);
        n_checks++; if (bc != 15) begin n_fail++; $display("FAIL lz_busy_cycles: got %0d expected 15", bc); end
        exp = '{8'hF8, 8'hFF, 8'hFF, 8'hFF};
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL lz_on_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
        blank_lz = 1'b0;
        exp = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL lz_off_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
    endtask

    task automatic test_overflow();
        int bc;
        logic [7:0] exp [4];
        blank_lz = 1'b0; dp_mask = '0;
        do_load(14'd10000, bc);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== 8'hBF) begin n_fail++; $display("FAIL ovf_dash[%0d]: got %h expected BF", d, obs_font[d]); end
        end
        do_load(14'd42, bc);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        exp = '{8'hA4, 8'h99, 8'hC0, 8'hC0};
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL ovf_42_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        logic [7:0] exp [4];
        blank_lz = 1'b0; dp_mask = 4'b0100;
        @(negedge clk);
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        value = 14'd9999;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            // cycle 15 is the last busy sample: that load meets the edge where busy falls
            load = (cyc == 5 || cyc == 15);
            @(negedge clk);
        end
        load = 1'b0;
        n_checks++; if (cyc != 15) begin n_fail++; $display("FAIL ignore_busy_cycles: got %0d expected 15", cyc); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_restart: got %b expected 0", busy); end
        exp = '{8'h80, 8'hF8, 8'h02, 8'h92};
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL ignore_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] exp_sel;
        blank_lz = 1'b0; dp_mask = '0;
        @(negedge clk);
        value = 14'd321;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (fndselect !== 4'hF) begin n_fail++; $display("FAIL midrst_sel: got %h expected F", fndselect); end
        n_checks++; if (fndfont !== 8'hFF) begin n_fail++; $display("FAIL midrst_font: got %h expected FF", fndfont); end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_sel = ~(4'b0001 << ((k - 1) / 4));
            n_checks++; if (fndselect !== exp_sel) begin n_fail++; $display("FAIL midrst_scan_sel[%0d]: got %h expected %h", k, fndselect, exp_sel); end
            n_checks++; if (fndfont !== 8'hC0) begin n_fail++; $display("FAIL midrst_scan_font[%0d]: got %h expected C0", k, fndfont); end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_zero_and_max();
        int bc;
        logic [7:0] exp [4];
        blank_lz = 1'b1; dp_mask = '0;
        do_load(14'd0, bc);
        n_checks++; if (bc != 15) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 15", bc); end
        exp = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== exp[d]) begin n_fail++; $display("FAIL zero_font[%0d]: got %h expected %h", d, obs_font[d], exp[d]); end
        end
        do_load(14'd16383, bc);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL max_overflow: got %b expected 1", overflow); end
        capture_scan();
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (obs_font[d] !== 8'hBF) begin n_fail++; $display("FAIL max_dash[%0d]: got %h expected BF", d, obs_font[d]); end
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_leading_zero();
        test_overflow();
        test_busy_ignore();
        test_reset_mid_shift();
        test_zero_and_max();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
